// File: rtl/piso_framer_pkg.sv
// Shared encodings for the parallel-in serial-out framer.
package piso_framer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/bit_period_timer.sv
// Counts DIV clocks per bit period; tick marks the last clock of each period while running.
module bit_period_timer #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [TW-1:0] tcnt_q, tcnt_d;

  assign tick = run && (tcnt_q == TW'(DIV - 1));

  always_comb begin
    tcnt_d = tcnt_q;
    if (!run || tick) tcnt_d = '0;
    else              tcnt_d = tcnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tcnt_q <= '0;
    else     tcnt_q <= tcnt_d;
  end

endmodule

// File: rtl/piso_framer.sv
// Start/stop framed MSB-first serializer with per-bit ser_en strobe.
// Optional even parity bit after the data when PISO_FRAMER_PARITY_EN is defined.
module piso_framer
  import piso_framer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_en,
  output logic             busy,
  output logic             frame_done
);

  localparam int BW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic             ser_out_q, ser_out_d;
  logic             tick;
  logic             accept;
`ifdef PISO_FRAMER_PARITY_EN
  logic             par_q, par_d;
`endif

  bit_period_timer #(.DIV(DIV)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .run  (state_q != ST_IDLE),
    .tick (tick)
  );

  // A word can be taken while idle or in the final STOP clock for gapless frames.
  assign in_ready   = (state_q == ST_IDLE) || ((state_q == ST_STOP) && tick);
  assign accept     = in_valid && in_ready;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = tick && (state_q == ST_STOP);
  assign ser_out    = ser_out_q;
`ifdef PISO_FRAMER_PARITY_EN
  assign ser_en     = tick && ((state_q == ST_DATA) || (state_q == ST_PARITY));
`else
  assign ser_en     = tick && (state_q == ST_DATA);
`endif

  // ser_out_d is the level of the next cycle, so the line only changes on period boundaries.
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bcnt_d    = bcnt_q;
    ser_out_d = ser_out_q;
`ifdef PISO_FRAMER_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        ser_out_d = LINE_IDLE;
        if (accept) begin
          state_d   = ST_START;
          sreg_d    = in_data;
          bcnt_d    = '0;
          ser_out_d = LINE_START;
`ifdef PISO_FRAMER_PARITY_EN
          par_d     = ^in_data;
`endif
        end
      end
      ST_START: begin
        if (tick) begin
          state_d   = ST_DATA;
          ser_out_d = sreg_q[WIDTH-1];
        end
      end
      ST_DATA: begin
        if (tick) begin
          sreg_d = sreg_q << 1;
          if (bcnt_q == BW'(WIDTH - 1)) begin
            bcnt_d    = '0;
`ifdef PISO_FRAMER_PARITY_EN
            state_d   = ST_PARITY;
            ser_out_d = par_q;
`else
            state_d   = ST_STOP;
            ser_out_d = LINE_IDLE;
`endif
          end else begin
            bcnt_d    = bcnt_q + 1'b1;
            ser_out_d = sreg_q[WIDTH-2];
          end
        end
      end
`ifdef PISO_FRAMER_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_d   = ST_STOP;
          ser_out_d = LINE_IDLE;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (accept) begin
            state_d   = ST_START;
            sreg_d    = in_data;
            bcnt_d    = '0;
            ser_out_d = LINE_START;
`ifdef PISO_FRAMER_PARITY_EN
            par_d     = ^in_data;
`endif
          end else begin
            state_d   = ST_IDLE;
            ser_out_d = LINE_IDLE;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        ser_out_d = LINE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bcnt_q    <= '0;
      ser_out_q <= LINE_IDLE;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      ser_out_q <= ser_out_d;
    end
  end

  // Word payload only; it is always reloaded on accept before use.
  always_ff @(posedge clk) begin
    sreg_q <= sreg_d;
`ifdef PISO_FRAMER_PARITY_EN
    par_q  <= par_d;
`endif
  end

endmodule

// File: tb/tb_piso_framer.sv
// Directed bench for piso_framer: DIV=4 and DIV=1 instances, per-clock line checks and a word scoreboard.
module tb_piso_framer;

  localparam int W = 8;
`ifdef PISO_FRAMER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam logic [4:0] IDLE_VEC = 5'b10010; // {ser_out, ser_en, frame_done, in_ready, busy}

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         a_valid, a_ready, a_out, a_en, a_busy, a_done;
  logic [W-1:0] a_data;
  logic         b_valid, b_ready, b_out, b_en, b_busy, b_done;
  logic [W-1:0] b_data;

  piso_framer #(.WIDTH(W), .DIV(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_data(a_data), .in_ready(a_ready),
    .ser_out(a_out), .ser_en(a_en), .busy(a_busy), .frame_done(a_done)
  );

  piso_framer #(.WIDTH(W), .DIV(1)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_data(b_data), .in_ready(b_ready),
    .ser_out(b_out), .ser_en(b_en), .busy(b_busy), .frame_done(b_done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] outs(input bit sel);
    if (sel) return {b_out, b_en, b_done, b_ready, b_busy};
    return {a_out, a_en, a_done, a_ready, a_busy};
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [W-1:0] d);
    if (sel) begin b_valid = v; b_data = d; end
    else     begin a_valid = v; a_data = d; end
  endtask

  function automatic logic exp_bit(input logic [W-1:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= W) return d[W-b];
    if (PB == 1 && b == W + 1) return ^d;
    return 1'b1;
  endfunction

  function automatic logic [4:0] exp_vec(input logic [W-1:0] d, input int k, input int div, input int len);
    int b;
    logic een;
    b   = (k - 1) / div;
    een = (b >= 1) && (b <= W + PB) && (((k - 1) % div) == div - 1);
    return {exp_bit(d, b), een, k == len, k == len, 1'b1};
  endfunction

  // Entered at the negedge before the accepting posedge; returns at the negedge of the last STOP clock.
  task automatic run_frame(input bit sel, input int div, input logic [W-1:0] d,
                           input logic nv, input logic [W-1:0] nd);
    int         len;
    int         en_cnt;
    logic [8:0] cap;
    logic [4:0] o;
    logic [W-1:0] want;
    len    = (W + 2 + PB) * div;
    en_cnt = 0;
    cap    = '0;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      o = outs(sel);
      chk($sformatf("frame_%0h_div%0d_clk%0d", d, div, k), o, exp_vec(d, k, div, len));
      if (o[3]) begin
        cap = {cap[7:0], o[4]};
        en_cnt++;
      end
      if (o[2]) begin
        chk("sb_nonempty", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          want = sb_q.pop_front();
          if (PB == 1) begin
            chk("captured_word", cap[8:1], want);
            chk("captured_parity", cap[0], ^want);
          end else begin
            chk("captured_word", cap[7:0], want);
          end
        end
      end
      if (k == 1) begin
        drive(sel, nv, nd);
        if (nv) sb_q.push_back(nd);
      end
    end
    chk("ser_en_count", en_cnt, W + PB);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_valid = 1'b0; a_data = '0;
    b_valid = 1'b0; b_data = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("in_reset_a", outs(0), IDLE_VEC);
    chk("in_reset_b", outs(1), IDLE_VEC);
    rst = 1'b0;

    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_a", outs(0), IDLE_VEC);
      chk("idle_b", outs(1), IDLE_VEC);
    end

    // Single frame 0xA5 at DIV=4
    drive(0, 1'b1, 8'hA5);
    sb_q.push_back(8'hA5);
    chk("ready_before_a5", a_ready, 1'b1);
    run_frame(0, 4, 8'hA5, 1'b0, '0);
    @(negedge clk);
    chk("idle_after_a5", outs(0), IDLE_VEC);

    // Back-to-back 0x3C, 0xC3 with in_valid held high
    drive(0, 1'b1, 8'h3C);
    sb_q.push_back(8'h3C);
    run_frame(0, 4, 8'h3C, 1'b1, 8'hC3);
    run_frame(0, 4, 8'hC3, 1'b0, '0);
    @(negedge clk);
    chk("idle_after_b2b", outs(0), IDLE_VEC);

    // DIV=1 with all ones
    drive(1, 1'b1, 8'hFF);
    sb_q.push_back(8'hFF);
    chk("ready_before_ff", b_ready, 1'b1);
    run_frame(1, 1, 8'hFF, 1'b0, '0);
    @(negedge clk);
    chk("idle_after_ff", outs(1), IDLE_VEC);

    // Odd-parity-count word
    drive(0, 1'b1, 8'h07);
    sb_q.push_back(8'h07);
    run_frame(0, 4, 8'h07, 1'b0, '0);
    @(negedge clk);

    // Asynchronous reset after three data bits
    drive(0, 1'b1, 8'h5A);
    sb_q.push_back(8'h5A);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk($sformatf("abort_clk%0d", k), outs(0), exp_vec(8'h5A, k, 4, (W + 2 + PB) * 4));
      if (k == 1) drive(0, 1'b0, '0);
    end
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", outs(0), IDLE_VEC);
    void'(sb_q.pop_front());
    chk("sb_after_abort", sb_q.size(), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("idle_after_abort", outs(0), IDLE_VEC);
    end

    drive(0, 1'b1, 8'h81);
    sb_q.push_back(8'h81);
    run_frame(0, 4, 8'h81, 1'b0, '0);
    @(negedge clk);
    chk("idle_final", outs(0), IDLE_VEC);
    chk("sb_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
